pipe_share_sched: RTL and testbench
===================================

Name: pipe_share_sched

Overview:
- Round-robin scheduler that shares one fixed-latency, non-stallable arithmetic pipeline among N requesters. The pipeline computes f = (a+b+(c-d))*d, mod 2^W.
- Arbitrates each cycle, registers the winner's operand set into the pipeline inputs, and tracks a valid/tag token alongside the datapath.
- When a result emerges, it is returned with the ID of the requester that issued it.
- Sits between the requester ports and the shared pipeline instance.

Parameters:
- N, 4, number of requesters (2..8); TW = clog2(N), local.
- W, 10, operand/result width.
- LAT, 3, pipeline latency in clock edges, from operands at pipeline inputs to valid f at pipeline output (1..8).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous: discard all in-flight work.
- req  in  N  per-requester request, level.
- op_a, op_b, op_c, op_d  in  N*W each  operand buses; requester i occupies bits [i*W +: W].
- gnt  out  N  one-hot; high for one cycle after requester's operands were captured.
- pipe_a, pipe_b, pipe_c, pipe_d  out  W each  registered operands to shared pipeline.
- pipe_vld  out  1  pipe_a..d hold a new issue this cycle.
- pipe_f  in  W  shared pipeline result.
- res_vld  out  1  res_f/res_tag valid this cycle.
- res_tag  out  TW  requester ID owning res_f.
- res_f  out  W  result (= pipe_f, passthrough).
- busy  out  1  pipe_vld or any tag-pipe entry valid.

Behaviour:
- Reset (rst_n low, async):
  - gnt=0, pipe_vld=0, pipe_a..d=0.
  - All tag-pipe valids=0, so res_vld=0 and busy=0.
  - res_tag=0; RR pointer=0.
- Eligibility: req[i] & ~gnt[i].
  - The currently granted requester is masked for that cycle.
  - Requester must hold req and operands stable until it sees gnt, and drop req in the gnt cycle.
  - Net effect: each requester gets at most one issue per two cycles.
- Arbitration, at each posedge with any eligible requester and flush=0:
  - Winner = first eligible index at or after ptr, searching upward modulo N.
  - gnt <= onehot(winner).
  - pipe_a..d <= winner's operands.
  - pipe_vld <= 1.
  - ptr <= (winner+1) mod N.
- No eligible requester: gnt <= 0, pipe_vld <= 0; pipe_a..d hold their previous value; ptr unchanged.
- Tag pipe:
  - LAT-deep shift register of {vld, tag}, loaded from {pipe_vld, winner ID of that issue}, advancing every cycle.
  - res_vld/res_tag are the final stage.
  - An issue whose pipe_vld rises after edge E0 gives res_vld=1 after edge E0+LAT, for exactly one cycle.
  - res_f = pipe_f combinationally; it is meaningful only when res_vld=1.
  - Throughput: one issue per cycle maximum; ordering is preserved.
- Flush, synchronous, priority over arbitration:
  - At the edge: gnt <= 0, pipe_vld <= 0, all tag valids <= 0.
  - No new grant in that cycle; ptr unchanged.
  - Requests still pending are re-arbitrated from the next edge.
- Reset mid-operation: all in-flight results are dropped; no res_vld until new issues arrive after release.
- No backpressure on results: consumer must accept res_vld every cycle.
- Wrap-around: ptr goes from N-1 to 0.
- Single eligible requester: wins regardless of ptr.

Test Plan:
- Single issue: req0 with a=10, b=10, c=6, d=3 → gnt=0001 one cycle; res_vld after LAT edges with res_tag=0, res_f=69; busy drops after it.
- All four requesting at once after reset. Operands: r0 (10,10,6,3); r1 (5,5,5,3); r2 (20,11,6,4); r3 (1,1,1,1).
  - gnt sequence: 0001, 0010, 0100, 1000 on consecutive cycles.
  - Results in tag order 0, 1, 2, 3 with f = 69, 36, 132, 2, on consecutive cycles.
- Fairness: issue r1, then req0 and req3 both eligible → r3 wins (ptr=2), then r0; ptr wraps to 1.
- Masking: r2 holds req high continuously, others idle → gnt[2] pulses every other cycle, never on two consecutive cycles.
- Flush: assert flush for one cycle two edges after issuing r0 and r1 → no res_vld for either; busy=0 the cycle after; a new r2 issue then returns normally, tag 2.
- Async reset: drop rst_n mid-stream between clock edges → all outputs 0 immediately; after release, r3 with (2,2,2,1) → res_f=5, tag 3.

Source files
------------

// File: rtl/pipe_share_sched.sv
// Round-robin scheduler sharing one fixed-latency arithmetic pipeline among N requesters.
// A {vld, tag} shadow pipe travels alongside the datapath so each result returns with its owner's ID.
module pipe_share_sched #(
  parameter int N   = 4,
  parameter int W   = 10,
  parameter int LAT = 3,
  localparam int TW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  op_a,
  input  logic [N*W-1:0]  op_b,
  input  logic [N*W-1:0]  op_c,
  input  logic [N*W-1:0]  op_d,
  output logic [N-1:0]    gnt,
  output logic [W-1:0]    pipe_a,
  output logic [W-1:0]    pipe_b,
  output logic [W-1:0]    pipe_c,
  output logic [W-1:0]    pipe_d,
  output logic            pipe_vld,
  input  logic [W-1:0]    pipe_f,
  output logic            res_vld,
  output logic [TW-1:0]   res_tag,
  output logic [W-1:0]    res_f,
  output logic            busy
);

  logic [TW-1:0]  ptr;
  logic [TW-1:0]  pipe_tag;
  logic [N-1:0]   elig;
  logic [TW-1:0]  idx;
  logic           win_vld;
  logic [TW-1:0]  win_id;
  logic [TW-1:0]  ptr_nxt;
  logic [LAT-1:0] vld_p;
  logic [TW-1:0]  tag_p [LAT];

  // Descending scan so the lowest offset from ptr is written last and wins.
  always_comb begin
    elig    = req & ~gnt;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = TW'((int'(ptr) + k) % N);
      if (elig[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
    ptr_nxt = (win_id == TW'(N - 1)) ? '0 : win_id + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      pipe_vld <= 1'b0;
      pipe_a   <= '0;
      pipe_b   <= '0;
      pipe_c   <= '0;
      pipe_d   <= '0;
      pipe_tag <= '0;
      ptr      <= '0;
      vld_p    <= '0;
      for (int i = 0; i < LAT; i++) tag_p[i] <= '0;
    end else begin
      // issue stage -> tag pipe stage 0 .. LAT-1
      vld_p    <= (vld_p << 1) | LAT'(pipe_vld);
      tag_p[0] <= pipe_tag;
      for (int i = 1; i < LAT; i++) tag_p[i] <= tag_p[i-1];

      if (flush) begin
        gnt      <= '0;
        pipe_vld <= 1'b0;
        vld_p    <= '0;
      end else if (win_vld) begin
        gnt      <= N'(1) << win_id;
        pipe_a   <= op_a[win_id*W +: W];
        pipe_b   <= op_b[win_id*W +: W];
        pipe_c   <= op_c[win_id*W +: W];
        pipe_d   <= op_d[win_id*W +: W];
        pipe_tag <= win_id;
        pipe_vld <= 1'b1;
        ptr      <= ptr_nxt;
      end else begin
        gnt      <= '0;
        pipe_vld <= 1'b0;
      end
    end
  end

  assign res_vld = vld_p[LAT-1];
  assign res_tag = tag_p[LAT-1];
  assign res_f   = pipe_f;
  assign busy    = pipe_vld | (|vld_p);

endmodule

// File: tb/tb_pipe_share_sched.sv
// Directed bench for pipe_share_sched with a 3-stage model of the shared pipeline
// f = (a+b+(c-d))*d attached to the pipe_* outputs.
module tb_pipe_share_sched;
  localparam int N = 4, W = 10, LAT = 3;

  logic           clk, rst_n, flush;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a, op_b, op_c, op_d;
  logic [N-1:0]   gnt;
  logic [W-1:0]   pipe_a, pipe_b, pipe_c, pipe_d, pipe_f, res_f;
  logic           pipe_vld, res_vld, busy;
  logic [1:0]     res_tag;

  int n_tests = 0;
  int n_fail  = 0;

  int oa[4]    = '{10, 5, 20, 1};
  int ob[4]    = '{10, 5, 11, 1};
  int oc[4]    = '{6, 5, 6, 1};
  int od[4]    = '{3, 3, 4, 1};
  int exp_f[4] = '{69, 36, 132, 2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_share_sched #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req(req),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
    .gnt(gnt), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c), .pipe_d(pipe_d),
    .pipe_vld(pipe_vld), .pipe_f(pipe_f), .res_vld(res_vld), .res_tag(res_tag),
    .res_f(res_f), .busy(busy)
  );

  // shared arithmetic pipeline, LAT = 3 register stages
  logic [W-1:0] f_now, pf0, pf1, pf2;
  assign f_now = (pipe_a + pipe_b + (pipe_c - pipe_d)) * pipe_d;
  always @(posedge clk) begin
    pf0 <= f_now;
    pf1 <= pf0;
    pf2 <= pf1;
  end
  assign pipe_f = pf2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
    op_a[i*W +: W] = W'(a);
    op_b[i*W +: W] = W'(b);
    op_c[i*W +: W] = W'(c);
    op_d[i*W +: W] = W'(d);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req = '0;
    op_a = '0; op_b = '0; op_c = '0; op_d = '0;
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_pvld", 32'(pipe_vld), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rvld", 32'(res_vld), 0);
    check("rst_tag", 32'(res_tag), 0);
    check("rst_pa", 32'(pipe_a), 0);
    step(); step();
    rst_n = 1'b1;

    // single issue
    set_ops(0, 10, 10, 6, 3);
    req = 4'b0001;
    step();
    check("one_gnt", 32'(gnt), 1);
    check("one_pvld", 32'(pipe_vld), 1);
    check("one_pa", 32'(pipe_a), 10);
    check("one_pd", 32'(pipe_d), 3);
    check("one_busy", 32'(busy), 1);
    req = '0;
    step();
    check("one_gnt_off", 32'(gnt), 0);
    check("one_rvld_e1", 32'(res_vld), 0);
    step();
    check("one_rvld_e2", 32'(res_vld), 0);
    step();
    check("one_rvld", 32'(res_vld), 1);
    check("one_tag", 32'(res_tag), 0);
    check("one_f", 32'(res_f), 69);
    check("one_busy_res", 32'(busy), 1);
    step();
    check("one_rvld_end", 32'(res_vld), 0);
    check("one_busy_end", 32'(busy), 0);

    // all four at once after reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, oa[i], ob[i], oc[i], od[i]);
    req = 4'b1111;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      step();
      check("all_gnt", 32'(gnt), (cyc <= 4) ? (1 << (cyc - 1)) : 0);
      if (cyc <= 4) check("all_pa", 32'(pipe_a), oa[cyc-1]);
      if (cyc >= 4) begin
        check("all_rvld", 32'(res_vld), 1);
        check("all_tag", 32'(res_tag), cyc - 4);
        check("all_f", 32'(res_f), exp_f[cyc-4]);
      end else begin
        check("all_rvld_early", 32'(res_vld), 0);
      end
      req = req & ~gnt;
    end
    step();
    check("all_rvld_end", 32'(res_vld), 0);
    check("all_busy_end", 32'(busy), 0);

    // fairness and pointer wrap (ptr = 0 here)
    req = 4'b0010;
    step();
    check("fair_r1", 32'(gnt), 4'b0010);
    req = 4'b1001;
    step();
    check("fair_r3", 32'(gnt), 4'b1000);
    req = req & ~gnt;
    step();
    check("fair_r0", 32'(gnt), 4'b0001);
    req = '0;
    step();
    check("fair_idle", 32'(gnt), 0);
    req = 4'b0011;
    step();
    check("wrap_ptr1", 32'(gnt), 4'b0010);
    req = req & ~gnt;
    step();
    check("wrap_r0", 32'(gnt), 4'b0001);
    req = '0;
    repeat (4) step();
    check("fair_busy_end", 32'(busy), 0);

    // masking: r2 holds req continuously
    req = 4'b0100;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step();
      check("mask_gnt", 32'(gnt), (cyc % 2 == 0) ? 4 : 0);
    end
    req = '0;
    repeat (4) step();

    // flush two edges after issuing r0, r1 (ptr = 3 here)
    req = 4'b0011;
    step();
    check("fl_r0", 32'(gnt), 4'b0001);
    req = 4'b0010;
    step();
    check("fl_r1", 32'(gnt), 4'b0010);
    flush = 1'b1;
    req = 4'b0100;
    step();
    check("fl_gnt", 32'(gnt), 0);
    check("fl_pvld", 32'(pipe_vld), 0);
    check("fl_busy", 32'(busy), 0);
    flush = 1'b0;
    step();
    check("fl_r2_gnt", 32'(gnt), 4'b0100);
    check("fl_drop0", 32'(res_vld), 0);
    req = '0;
    step();
    check("fl_drop1", 32'(res_vld), 0);
    step();
    check("fl_wait", 32'(res_vld), 0);
    step();
    check("fl_r2_vld", 32'(res_vld), 1);
    check("fl_r2_tag", 32'(res_tag), 2);
    check("fl_r2_f", 32'(res_f), 132);

    // asynchronous reset mid-stream
    req = 4'b0011;
    step();
    check("ar_r0", 32'(gnt), 4'b0001);
    req = 4'b0010;
    step();
    check("ar_r1", 32'(gnt), 4'b0010);
    req = '0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_gnt", 32'(gnt), 0);
    check("ar_pvld", 32'(pipe_vld), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_rvld", 32'(res_vld), 0);
    check("ar_pa", 32'(pipe_a), 0);
    check("ar_tag", 32'(res_tag), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      step();
      check("ar_dropped", 32'(res_vld), 0);
    end
    set_ops(3, 2, 2, 2, 1);
    req = 4'b1000;
    step();
    check("ar_r3_gnt", 32'(gnt), 4'b1000);
    req = '0;
    step(); step(); step();
    check("ar_r3_vld", 32'(res_vld), 1);
    check("ar_r3_tag", 32'(res_tag), 3);
    check("ar_r3_f", 32'(res_f), 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
